// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_pkg
// Brief    : Line types, PID codes and SYNC constant shared by usb_rx/usb_tx.
// Revision : 1.0
// ============================================================================
package usb_rx_pkg;

    typedef struct packed {
        logic p;
        logic n;
    } d_port_t;

    typedef enum logic [1:0] {
        J   = 2'd0,
        K   = 2'd1,
        SE0 = 2'd2,
        SE1 = 2'd3
    } line_state_t;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    // Decoded SYNC bits held LSB first: seven zeros then a one (KJKJKJKK on the wire).
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Low-speed levels: J = p0/n1, K = p1/n0.
    function automatic line_state_t decode_line(input d_port_t lines);
        case ({lines.p, lines.n})
            2'b01:   decode_line = J;
            2'b10:   decode_line = K;
            2'b00:   decode_line = SE0;
            default: decode_line = SE1;
        endcase
    endfunction

    function automatic logic is_se0(input line_state_t ls);
        return (ls == SE0) || (ls == SE1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_dpll.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_dpll
// Brief    : Input synchronizer, line-state decode and mid-bit sample strobe.
// Revision : 1.0
// ============================================================================
module usb_rx_dpll
    import usb_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  d_port_t     d,
    output logic        sample,
    output line_state_t line
);

    localparam logic [1:0] SAMPLE_PHASE = 2'(CLK_PER_BIT / 2);
    localparam d_port_t    LINE_IDLE    = '{p: 1'b0, n: 1'b1};

    d_port_t     r_sync1;
    d_port_t     r_sync2;
    line_state_t r_line;
    logic [1:0]  r_phase;
    line_state_t w_line;

    assign w_line = decode_line(r_sync2);
    assign sample = (r_phase == SAMPLE_PHASE);
    assign line   = r_line;

    // Every edge on the line re-centres the phase so the strobe lands mid-bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= LINE_IDLE;
            r_sync2 <= LINE_IDLE;
            r_line  <= J;
            r_phase <= 2'd0;
        end else begin
            r_sync1 <= d;
            r_sync2 <= r_sync1;
            if (w_line != r_line) begin
                r_line  <= w_line;
                r_phase <= 2'd0;
            end else begin
                r_phase <= r_phase + 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_rx.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx
// Brief    : Low-speed USB receiver: SYNC detect, NRZI decode, unstuff, bytes.
// Options  : USB_RX_PID_CHECK_EN enables the PID/complement check on byte one.
// Revision : 1.0
// ============================================================================
module usb_rx
    import usb_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = 4,
    parameter int SYNC_LEN    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  d_port_t     d,
    output logic [7:0]  data,
    output logic        valid,
    output logic        active,
    output logic        eop,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_DATA      = 3'd2,
        ST_EOP       = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    state_t      r_state, w_state_n;
    line_state_t r_prev, w_prev_n;
    logic [2:0]  r_bitcnt, w_bitcnt_n;
    logic [6:0]  r_shift, w_shift_n;
    logic [2:0]  r_ones, w_ones_n;
    logic        r_jseen, w_jseen_n;
    logic [7:0]  w_data_n;
    logic        w_valid_n, w_active_n, w_eop_n, w_error_n;
    logic        w_sample;
    line_state_t w_line;
    logic        w_bit;
    logic [7:0]  w_byte;
`ifdef USB_RX_PID_CHECK_EN
    logic        r_first, w_first_n;
`endif

    usb_rx_dpll #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_dpll (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .sample (w_sample),
        .line   (w_line)
    );

    assign w_bit  = (w_line == r_prev);
    assign w_byte = {w_bit, r_shift};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_prev   <= J;
            r_bitcnt <= 3'd0;
            r_shift  <= 7'd0;
            r_ones   <= 3'd0;
            r_jseen  <= 1'b0;
            data     <= 8'd0;
            valid    <= 1'b0;
            active   <= 1'b0;
            eop      <= 1'b0;
            error    <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
            r_first  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_n;
            r_prev   <= w_prev_n;
            r_bitcnt <= w_bitcnt_n;
            r_shift  <= w_shift_n;
            r_ones   <= w_ones_n;
            r_jseen  <= w_jseen_n;
            data     <= w_data_n;
            valid    <= w_valid_n;
            active   <= w_active_n;
            eop      <= w_eop_n;
            error    <= w_error_n;
`ifdef USB_RX_PID_CHECK_EN
            r_first  <= w_first_n;
`endif
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_prev_n   = r_prev;
        w_bitcnt_n = r_bitcnt;
        w_shift_n  = r_shift;
        w_ones_n   = r_ones;
        w_jseen_n  = r_jseen;
        w_data_n   = data;
        w_valid_n  = 1'b0;
        w_active_n = active;
        w_eop_n    = 1'b0;
        w_error_n  = 1'b0;
`ifdef USB_RX_PID_CHECK_EN
        w_first_n  = r_first;
`endif
        if (w_sample) begin
            case (r_state)
                ST_IDLE: begin
                    w_prev_n = J;
                    if (w_line == K) begin
                        w_state_n  = ST_SYNC;
                        w_prev_n   = K;
                        w_bitcnt_n = 3'd1;
                    end
                end
                ST_SYNC: begin
                    w_prev_n = w_line;
                    if (is_se0(w_line) || (w_bit != SYNC_PATTERN[r_bitcnt])) begin
                        w_error_n = 1'b1;
                        w_jseen_n = 1'b0;
                        w_state_n = ST_WAIT_IDLE;
                    end else if (r_bitcnt == 3'(SYNC_LEN - 1)) begin
                        w_state_n  = ST_DATA;
                        w_active_n = 1'b1;
                        w_bitcnt_n = 3'd0;
                        w_ones_n   = 3'd0;
`ifdef USB_RX_PID_CHECK_EN
                        w_first_n  = 1'b1;
`endif
                    end else begin
                        w_bitcnt_n = r_bitcnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    w_prev_n = w_line;
                    if (is_se0(w_line)) begin
                        w_state_n = ST_EOP;
                    end else if (r_ones == 3'd6) begin
                        // Bit after six ones must be a stuffed zero; it carries no data.
                        if (w_bit) begin
                            w_error_n  = 1'b1;
                            w_active_n = 1'b0;
                            w_jseen_n  = 1'b0;
                            w_state_n  = ST_WAIT_IDLE;
                        end else begin
                            w_ones_n = 3'd0;
                        end
                    end else begin
                        w_shift_n  = w_byte[7:1];
                        w_ones_n   = w_bit ? r_ones + 3'd1 : 3'd0;
                        w_bitcnt_n = r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
`ifdef USB_RX_PID_CHECK_EN
                            w_first_n = 1'b0;
                            if (r_first && (w_byte[7:4] != ~w_byte[3:0])) begin
                                w_error_n  = 1'b1;
                                w_active_n = 1'b0;
                                w_jseen_n  = 1'b0;
                                w_state_n  = ST_WAIT_IDLE;
                            end else begin
                                w_data_n  = w_byte;
                                w_valid_n = 1'b1;
                            end
`else
                            w_data_n  = w_byte;
                            w_valid_n = 1'b1;
`endif
                        end
                    end
                end
                ST_EOP: begin
                    if (w_line == J) begin
                        w_eop_n    = 1'b1;
                        w_error_n  = (r_bitcnt != 3'd0);
                        w_active_n = 1'b0;
                        w_prev_n   = J;
                        w_state_n  = ST_IDLE;
                    end else if (w_line == K) begin
                        w_error_n  = 1'b1;
                        w_active_n = 1'b0;
                        w_jseen_n  = 1'b0;
                        w_state_n  = ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    w_active_n = 1'b0;
                    w_jseen_n  = (w_line == J);
                    if ((w_line == J) && r_jseen) begin
                        w_prev_n  = J;
                        w_state_n = ST_IDLE;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/usb_rx.md
Name: usb_rx

Overview:
Low-speed (1.5 Mbit/s) USB packet receiver and the counterpart of usb_tx; it shares its clock, package and data conventions.
- Clock runs at 4x bit rate (6 MHz).
- Recovers bit timing from the D+/D- line, detects SYNC, NRZI-decodes and bit-unstuffs, and assembles bytes LSB first.
- Reports bytes, end-of-packet and errors to the protocol engine above.
- No backpressure: the line cannot be stalled.

Parameters:
CLK_PER_BIT, 4, clock cycles per USB bit; only 4 is supported.
SYNC_LEN, 8, SYNC field length in bits.

Ports:
clk  in  1  system clock, 4x bit rate.
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
d  in  d_port_t  raw bus lines d.p / d.n, asynchronous.
data  out  8  received byte, LSB = first bit on wire.
valid  out  1  one-cycle strobe; data is new this cycle.
active  out  1  high from SYNC detection until EOP or abort.
eop  out  1  one-cycle strobe at end of packet.
error  out  1  one-cycle strobe on stuff, alignment or SYNC error.

Behaviour:
- Reset values: data=0, valid=0, active=0, eop=0, error=0; FSM in IDLE; DPLL phase=0.
- Input path:
  - d passes through a 2-flop synchronizer.
  - Line state is decoded from the synchronized p/n (low speed): J = p0/n1, K = p1/n0, SE0 = p0/n0, SE1 = p1/n1. SE1 is treated as SE0.
- DPLL:
  - 2-bit phase counter; reset to 0 on any line-state change.
  - Sample strobe at phase==2, i.e. mid-bit.
- NRZI:
  - Decoded bit = 1 if sampled state equals the previous sample, else 0.
  - Previous sample is J in IDLE.
- FSM states:
  - IDLE: J line. K sampled -> SYNC.
  - SYNC: expects the KJKJKJKK pattern (decoded 0000_0001 for SYNC_LEN=8). Match -> DATA, active=1. Mismatch or SE0 -> error strobe, then WAIT_IDLE.
  - DATA: see bit-unstuffing below.
    - Every 8 unstuffed bits -> data updated and valid=1 for one cycle, 1 cycle after the 8th bit's sample strobe.
    - SE0 sampled -> EOP.
  - EOP:
    - SE0 followed by a J sample -> eop=1 for one cycle, active=0, -> IDLE.
    - If unstuffed bit count mod 8 != 0 at the SE0, error=1 in the same cycle as eop; the partial byte is discarded.
  - WAIT_IDLE: active=0. Stays until a J has been sampled for 2 consecutive bits, then -> IDLE.
- Bit-unstuffing (DATA state):
  - A counter tracks consecutive decoded 1s.
  - After six 1s the next bit is dropped if it is 0.
  - If that bit is 1: error=1, active=0, -> WAIT_IDLE.
  - SYNC bits do not count towards the stuff counter.
- Simultaneous events: a byte completing on the same sample that begins SE0 is still delivered (valid), with eop following.
- Reset mid-packet: immediate return to the reset state; no eop or error strobe.
- valid, eop and error are never high for more than one cycle; valid and eop are never high in the same cycle.

Optional Feature:
USB_RX_PID_CHECK_EN:
- Defined: the first byte after SYNC is checked, requiring data[7:4] == ~data[3:0].
  - On mismatch: valid is suppressed for that byte, error=1, -> WAIT_IDLE.
- Undefined: the PID byte is delivered unchecked like any other byte.

Decomposition:
- Package types (shared with usb_tx):
  - d_port_t (packed struct p, n).
  - line_state_t enum {J, K, SE0, SE1}.
  - pid_t enum.
  - SYNC pattern constant.
- Sub-module usb_rx_dpll: synchronizer, line-state decode, phase counter. Outputs the sample strobe plus the sampled line state.

Test Plan:
- Reset during idle J, release after 3 clocks -> all outputs 0, active=0.
- Send SYNC + byte 8'hA5 + 8'h3C + EOP (2 bit-time SE0, then J) -> valid twice with data A5 then 3C, eop once, error never.
- Send SYNC + 8'hFF, 8'hFF with stuffed zeros inserted -> data FF, FF, eop, no error. Same stream with one stuffed 0 replaced by 1 -> error strobe, active drops, no eop.
- Jitter: vary bit period by ±1 clk (3 or 5 clocks) within a packet of 8'h55 -> correct data 55, no error.
- SYNC + 12 bits + EOP -> one valid, then eop and error in the same cycle. Reset asserted mid-byte -> outputs 0, next packet received correctly.
- With USB_RX_PID_CHECK_EN: PID byte 8'hC3 (DATA0) accepted; 8'hC4 -> no valid, error=1, subsequent bytes ignored until idle.
